// File: rtl/imem_boot_loader.sv
// Instruction memory boot loader.
// Takes a framed byte stream: a 16-bit word count (MSB first), that many 16-bit
// words (MSB first), then one checksum byte. Writes each word into IM at
// consecutive addresses from BASE_ADDR. Keeps the core held until a frame with
// a good checksum has been loaded. DONE and ERROR are terminal until rst.
//
// Handshake: a byte moves when in_valid && in_ready are both high on a rising
// clk edge. in_ready is a registered output. It rises on the first edge after
// rst is released and stays high until the FSM reaches DONE or ERROR. The
// source may drop in_valid on any cycle.
module imem_boot_loader #(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter int          IM_DEPTH  = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        im_wr_en,
   output logic [15:0] im_wr_addr,
   output logic [15:0] im_wr_data,
   output logic        core_hold,
   output logic        done,
   output logic        error,
   output logic [15:0] words_loaded,
   output logic [2:0]  fsm_state
);

   typedef enum logic [2:0] {
      ST_HDR_HI = 3'd0,
      ST_HDR_LO = 3'd1,
      ST_DAT_HI = 3'd2,
      ST_DAT_LO = 3'd3,
      ST_CSUM   = 3'd4,
      ST_DONE   = 3'd5,
      ST_ERROR  = 3'd6
   } state_t;

   localparam logic [16:0] DEPTH17 = 17'(IM_DEPTH);

   state_t      state;
   logic [7:0]  hdr_hi;
   logic [15:0] n_words;
   logic [7:0]  dat_hi;
   logic [7:0]  sum;

   logic        accept;
   logic [15:0] hdr_n;
   logic [16:0] frame_end;
   logic [7:0]  sum_next;
   logic [15:0] wl_next;

   assign accept    = in_valid && in_ready;
   assign hdr_n     = {hdr_hi, in_data};
   // 17-bit sum so that a header of 16'hFFFF cannot wrap past the size check
   assign frame_end = {1'b0, BASE_ADDR} + {1'b0, hdr_n};
   assign sum_next  = sum + in_data;
   assign wl_next   = words_loaded + 16'd1;
   assign fsm_state = state;

   // Frame FSM: header decode, word assembly, IM write strobe, checksum verdict
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_HDR_HI;
         in_ready     <= 1'b0;
         im_wr_en     <= 1'b0;
         im_wr_addr   <= 16'h0000;
         im_wr_data   <= 16'h0000;
         core_hold    <= 1'b1;
         done         <= 1'b0;
         error        <= 1'b0;
         words_loaded <= 16'h0000;
         hdr_hi       <= 8'h00;
         n_words      <= 16'h0000;
         dat_hi       <= 8'h00;
         sum          <= 8'h00;
      end else begin
         im_wr_en <= 1'b0;
         if (state != ST_DONE && state != ST_ERROR) begin
            in_ready <= 1'b1;
         end
         if (accept) begin
            sum <= sum_next;
            case (state)
               ST_HDR_HI: begin
                  hdr_hi <= in_data;
                  state  <= ST_HDR_LO;
               end
               ST_HDR_LO: begin
                  n_words <= hdr_n;
                  if (frame_end > DEPTH17) begin
                     state    <= ST_ERROR;
                     error    <= 1'b1;
                     in_ready <= 1'b0;
                  end else if (hdr_n == 16'h0000) begin
                     state <= ST_CSUM;
                  end else begin
                     state <= ST_DAT_HI;
                  end
               end
               ST_DAT_HI: begin
                  dat_hi <= in_data;
                  state  <= ST_DAT_LO;
               end
               ST_DAT_LO: begin
                  // words_loaded doubles as the index of the word being written
                  im_wr_en     <= 1'b1;
                  im_wr_addr   <= BASE_ADDR + words_loaded;
                  im_wr_data   <= {dat_hi, in_data};
                  words_loaded <= wl_next;
                  state        <= (wl_next == n_words) ? ST_CSUM : ST_DAT_HI;
               end
               ST_CSUM: begin
                  in_ready <= 1'b0;
                  if (sum_next == 8'h00) begin
                     state     <= ST_DONE;
                     done      <= 1'b1;
                     core_hold <= 1'b0;
                  end else begin
                     state <= ST_ERROR;
                     error <= 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: directed frames plus randomized frames, all
// checked against a frame-level reference model of the loader.
module tb_imem_boot_loader;
   localparam logic [15:0] BASE  = 16'h0000;
   localparam int          DEPTH = 4096;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        im_wr_en;
   logic [15:0] im_wr_addr;
   logic [15:0] im_wr_data;
   logic        core_hold;
   logic        done;
   logic        error;
   logic [15:0] words_loaded;
   logic [2:0]  fsm_state;

   int checks = 0;
   int errors = 0;

   // expected writes: {words_loaded after write, address, data}
   logic [47:0] exp_q[$];
   logic [47:0] mon_e;
   logic [7:0]  frame[$];

   logic        m_done;
   logic        m_err;
   logic [15:0] m_wl;

   imem_boot_loader #(.BASE_ADDR(BASE), .IM_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .im_wr_en     (im_wr_en),
      .im_wr_addr   (im_wr_addr),
      .im_wr_data   (im_wr_data),
      .core_hold    (core_hold),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded),
      .fsm_state    (fsm_state)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // write monitor / scoreboard
   always @(negedge clk) begin
      if (im_wr_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", 32'(im_wr_en), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", 32'(im_wr_addr), 32'(mon_e[31:16]));
            check("wr_data", 32'(im_wr_data), 32'(mon_e[15:0]));
            check("wr_count", 32'(words_loaded), 32'(mon_e[47:32]));
         end
      end
   end

   // reference model: derives writes and verdict from the frame bytes
   task automatic model_frame();
      int n;
      int s;
      n = {frame[0], frame[1]};
      if (int'(BASE) + n > DEPTH) begin
         m_err  = 1'b1;
         m_done = 1'b0;
         m_wl   = 16'd0;
      end else begin
         for (int i = 0; i < n; i++) begin
            exp_q.push_back({16'(i + 1), 16'(int'(BASE) + i), frame[2 + 2 * i], frame[3 + 2 * i]});
         end
         s = 0;
         foreach (frame[i]) s += int'(frame[i]);
         m_done = ((s % 256) == 0);
         m_err  = !m_done;
         m_wl   = 16'(n);
      end
   endtask

   // driver: gap 0 = continuous, 1 = valid on alternate cycles, 2 = random gaps
   task automatic drive(input int gap);
      int  idx;
      int  cyc;
      logic acc;
      logic v;
      idx = 0;
      cyc = 0;
      acc = 1'b0;
      forever begin
         @(negedge clk);
         if (acc) idx++;
         if (idx >= frame.size()) break;
         if (cyc >= 2000) begin
            check("drive_timeout", 32'(idx), 32'(frame.size()));
            break;
         end
         cyc++;
         case (gap)
            0:       v = 1'b1;
            1:       v = (cyc % 2) == 0;
            default: v = $urandom_range(0, 3) != 0;
         endcase
         in_valid = v;
         in_data  = v ? frame[idx] : 8'($urandom);
         acc      = v && in_ready;
      end
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      exp_q.delete();
      @(negedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_wr_en", 32'(im_wr_en), 32'd0);
      check("rst_wr_addr", 32'(im_wr_addr), 32'd0);
      check("rst_wr_data", 32'(im_wr_data), 32'd0);
      check("rst_core_hold", 32'(core_hold), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_words", 32'(words_loaded), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
   endtask

   // send a complete frame and check the verdict the cycle after the last byte
   task automatic run_frame(input string name, input int gap);
      model_frame();
      drive(gap);
      #1;
      check({name, "_done"}, 32'(done), 32'(m_done));
      check({name, "_error"}, 32'(error), 32'(m_err));
      check({name, "_core_hold"}, 32'(core_hold), 32'(!m_done));
      check({name, "_in_ready"}, 32'(in_ready), 32'd0);
      check({name, "_words"}, 32'(words_loaded), 32'(m_wl));
      check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
      check({name, "_exclusive"}, 32'(done & error), 32'd0);
      // terminal states ignore further input
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 8'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check({name, "_hold_done"}, 32'(done), 32'(m_done));
      check({name, "_hold_error"}, 32'(error), 32'(m_err));
      check({name, "_hold_words"}, 32'(words_loaded), 32'(m_wl));
   endtask

   initial begin
      int n;
      logic [7:0] b;
      int s;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      do_reset();

      frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
      run_frame("t1_good", 0);
      do_reset();

      frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
      run_frame("t2_badsum", 0);
      do_reset();

      frame = '{8'h00, 8'h00, 8'h00};
      run_frame("t3_empty", 0);
      do_reset();

      frame = '{8'h10, 8'h01};
      run_frame("t4_oversize", 0);
      do_reset();

      frame = '{8'hFF, 8'hFF};
      run_frame("ffff_oversize", 2);
      do_reset();

      // N exactly IM_DEPTH is accepted: loader moves on to data bytes
      frame = '{8'h10, 8'h00};
      drive(0);
      @(negedge clk);
      #1;
      check("n4096_error", 32'(error), 32'd0);
      check("n4096_in_ready", 32'(in_ready), 32'd1);
      check("n4096_core_hold", 32'(core_hold), 32'd1);
      do_reset();

      frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
      run_frame("t5_gaps", 1);
      do_reset();

      // reset after the first word has been written, then reload
      frame = '{8'h00, 8'h02, 8'h12, 8'h34};
      exp_q.push_back({16'd1, BASE, 16'h1234});
      drive(0);
      #1;
      check("t6_first_written", 32'(exp_q.size()), 32'd0);
      check("t6_words_before", 32'(words_loaded), 32'd1);
      do_reset();
      check("t6_words_after_rst", 32'(words_loaded), 32'd0);
      frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
      run_frame("t6_reload", 0);
      do_reset();

      // randomized frames with random gaps and occasional bad checksums
      for (int f = 0; f < 10; f++) begin
         n = $urandom_range(0, 6);
         frame.delete();
         frame.push_back(8'h00);
         frame.push_back(8'(n));
         for (int i = 0; i < 2 * n; i++) begin
            b = 8'($urandom);
            frame.push_back(b);
         end
         s = 0;
         foreach (frame[i]) s += int'(frame[i]);
         b = 8'((256 - (s % 256)) % 256);
         if ($urandom_range(0, 2) == 0) b = b + 8'($urandom_range(1, 255));
         frame.push_back(b);
         run_frame("rand", 2);
         do_reset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
